// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU-first priority with a starvation counter that
// forces a DMA grant, plus registered read-data return per port.
module dmem_arbiter #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,

   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [DATA_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_gnt,
   output logic                  cpu_rvalid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,

   input  logic                  dma_req,
   input  logic                  dma_we,
   input  logic [DATA_WIDTH-1:0] dma_addr,
   input  logic [DATA_WIDTH-1:0] dma_wdata,
   output logic                  dma_gnt,
   output logic                  dma_rvalid,
   output logic [DATA_WIDTH-1:0] dma_rdata,

   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

   logic [3:0]            starve_q, starve_d;
   logic                  starve_hit;
   logic                  cpu_rvalid_q, dma_rvalid_q;
   logic [DATA_WIDTH-1:0] cpu_rdata_q, dma_rdata_q;

   // With STARVE_LIMIT = 0 the counter never leaves 0, so DMA always wins.
   always_comb begin
      starve_hit = (starve_q == StarveMax);
      cpu_gnt    = reset_n & cpu_req & ~(dma_req & starve_hit);
      dma_gnt    = reset_n & dma_req & (~cpu_req | starve_hit);
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (cpu_gnt) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_we    = cpu_we;
      end else if (dma_gnt) begin
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         mem_we    = dma_we;
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (!dma_req || dma_gnt) begin
         starve_d = 4'd0;
      end else if (!starve_hit) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_q <= 4'd0;
      end else begin
         starve_q <= starve_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cpu_rvalid_q <= 1'b0;
         dma_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
      end else begin
         cpu_rvalid_q <= cpu_gnt & ~cpu_we;
         dma_rvalid_q <= dma_gnt & ~dma_we;
         if (cpu_gnt && !cpu_we) begin
            cpu_rdata_q <= mem_rdata;
         end
         if (dma_gnt && !dma_we) begin
            dma_rdata_q <= mem_rdata;
         end
      end
   end

   assign cpu_rvalid = cpu_rvalid_q;
   assign dma_rvalid = dma_rvalid_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a starve-limit-4 instance with a small word memory,
// and a starve-limit-0 instance with an address-derived read pattern.
module tb_dmem_arbiter;

   logic        clk;
   logic        reset_n;

   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
   logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

   logic        z_cpu_req, z_cpu_we, z_dma_req, z_dma_we;
   logic [31:0] z_cpu_addr, z_cpu_wdata, z_dma_addr, z_dma_wdata;
   logic        z_cpu_gnt, z_cpu_rvalid, z_dma_gnt, z_dma_rvalid, z_mem_we;
   logic [31:0] z_cpu_rdata, z_dma_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;

   logic [31:0] mem [0:255];

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic [13:0] dma_pat;
   logic [13:0] exp_dma;

   dmem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_gnt    (dma_gnt),
      .dma_rvalid (dma_rvalid),
      .dma_rdata  (dma_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata)
   );

   dmem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(0)) dut_z (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_req    (z_cpu_req),
      .cpu_we     (z_cpu_we),
      .cpu_addr   (z_cpu_addr),
      .cpu_wdata  (z_cpu_wdata),
      .cpu_gnt    (z_cpu_gnt),
      .cpu_rvalid (z_cpu_rvalid),
      .cpu_rdata  (z_cpu_rdata),
      .dma_req    (z_dma_req),
      .dma_we     (z_dma_we),
      .dma_addr   (z_dma_addr),
      .dma_wdata  (z_dma_wdata),
      .dma_gnt    (z_dma_gnt),
      .dma_rvalid (z_dma_rvalid),
      .dma_rdata  (z_dma_rdata),
      .mem_addr   (z_mem_addr),
      .mem_wdata  (z_mem_wdata),
      .mem_we     (z_mem_we),
      .mem_rdata  (z_mem_rdata)
   );

   assign mem_rdata   = mem[mem_addr[9:2]];
   assign z_mem_rdata = z_mem_addr ^ 32'hA5A5_0000;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
   endtask

   initial begin
      idle();
      z_cpu_req = 0; z_cpu_we = 0; z_cpu_addr = 0; z_cpu_wdata = 0;
      z_dma_req = 0; z_dma_we = 0; z_dma_addr = 0; z_dma_wdata = 0;
      dma_pat = 14'b11_1111_1111_0111;
      exp_dma = 14'b10_0001_0000_0000;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;

      // Requests during reset must be ignored
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'd77;
      dma_req = 1; dma_we = 1; dma_addr = 32'h104; dma_wdata = 32'h1234;
      tick();
      check("rst_cpu_gnt", 32'(cpu_gnt), 0);
      check("rst_dma_gnt", 32'(dma_gnt), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
      check("rst_dma_rvalid", 32'(dma_rvalid), 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_dma_rdata", dma_rdata, 0);
      idle();
      tick();
      reset_n = 1'b1;
      #1;
      check("idle_mem_addr", mem_addr, 0);
      check("idle_cpu_gnt", 32'(cpu_gnt), 0);

      // CPU writes 77 to 0x80 then reads it back
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'd77;
      #1;
      check("wr80_cpu_gnt", 32'(cpu_gnt), 1);
      check("wr80_dma_gnt", 32'(dma_gnt), 0);
      check("wr80_mem_we", 32'(mem_we), 1);
      check("wr80_mem_addr", mem_addr, 32'h80);
      check("wr80_mem_wdata", mem_wdata, 32'd77);
      tick();
      cpu_we = 0;
      #1;
      check("rd80_cpu_gnt", 32'(cpu_gnt), 1);
      check("rd80_mem_we", 32'(mem_we), 0);
      check("wr_no_rvalid", 32'(cpu_rvalid), 0);
      tick();
      check("rd80_cpu_rvalid", 32'(cpu_rvalid), 1);
      check("rd80_cpu_rdata", cpu_rdata, 32'd77);
      check("rd80_dma_rvalid", 32'(dma_rvalid), 0);

      // Preload 42 at 0x100
      cpu_we = 1; cpu_addr = 32'h100; cpu_wdata = 32'd42;
      tick();
      check("wr100_no_rvalid", 32'(cpu_rvalid), 0);
      check("rdata_hold", cpu_rdata, 32'd77);

      // DMA writes all-ones to 0x104 with CPU idle, CPU reads it back
      idle();
      dma_req = 1; dma_we = 1; dma_addr = 32'h104; dma_wdata = 32'hFFFF_FFFF;
      #1;
      check("dwr_dma_gnt", 32'(dma_gnt), 1);
      check("dwr_cpu_gnt", 32'(cpu_gnt), 0);
      check("dwr_mem_addr", mem_addr, 32'h104);
      check("dwr_mem_wdata", mem_wdata, 32'hFFFF_FFFF);
      check("dwr_mem_we", 32'(mem_we), 1);
      tick();
      idle();
      cpu_req = 1; cpu_addr = 32'h104;
      #1;
      check("rd104_cpu_gnt", 32'(cpu_gnt), 1);
      tick();
      check("rd104_cpu_rvalid", 32'(cpu_rvalid), 1);
      check("rd104_cpu_rdata", cpu_rdata, 32'hFFFF_FFFF);
      check("dwr_no_rvalid", 32'(dma_rvalid), 0);

      // Alternating single-port reads
      for (int i = 0; i < 4; i++) begin
         idle();
         if (i % 2 == 0) begin
            cpu_req = 1; cpu_addr = 32'h100;
         end else begin
            dma_req = 1; dma_addr = 32'h80;
         end
         #1;
         check("alt_cpu_gnt", 32'(cpu_gnt), 32'(i % 2 == 0));
         check("alt_dma_gnt", 32'(dma_gnt), 32'(i % 2 == 1));
         tick();
         check("alt_cpu_rvalid", 32'(cpu_rvalid), 32'(i % 2 == 0));
         check("alt_dma_rvalid", 32'(dma_rvalid), 32'(i % 2 == 1));
         if (i % 2 == 0) check("alt_cpu_rdata", cpu_rdata, 32'd42);
         else            check("alt_dma_rdata", dma_rdata, 32'd77);
      end

      // Contention: CPU always requests, DMA drops once to clear the counter
      idle();
      cpu_addr = 32'h100; dma_addr = 32'h80;
      for (int i = 0; i < 14; i++) begin
         cpu_req = 1;
         dma_req = dma_pat[i];
         #1;
         check("st_cpu_gnt", 32'(cpu_gnt), 32'(!exp_dma[i]));
         check("st_dma_gnt", 32'(dma_gnt), 32'(exp_dma[i]));
         check("st_mem_addr", mem_addr, exp_dma[i] ? 32'h80 : 32'h100);
         tick();
         check("st_cpu_rvalid", 32'(cpu_rvalid), 32'(!exp_dma[i]));
         check("st_dma_rvalid", 32'(dma_rvalid), 32'(exp_dma[i]));
      end
      check("st_dma_rdata", dma_rdata, 32'd77);

      // Reset in the middle of a granted read
      cpu_req = 1; dma_req = 1;
      tick();
      #1 reset_n = 1'b0;
      #1;
      check("mr_cpu_gnt", 32'(cpu_gnt), 0);
      check("mr_dma_gnt", 32'(dma_gnt), 0);
      check("mr_mem_we", 32'(mem_we), 0);
      check("mr_mem_addr", mem_addr, 0);
      check("mr_cpu_rvalid", 32'(cpu_rvalid), 0);
      check("mr_cpu_rdata", cpu_rdata, 0);
      check("mr_dma_rdata", dma_rdata, 0);
      tick();
      check("mr_pending_rvalid", 32'(cpu_rvalid), 0);
      reset_n = 1'b1;
      #1;
      check("mr_post_rvalid", 32'(cpu_rvalid), 0);
      for (int i = 0; i < 5; i++) begin
         check("mr_cpu_gnt_seq", 32'(cpu_gnt), 32'(i < 4));
         check("mr_dma_gnt_seq", 32'(dma_gnt), 32'(i == 4));
         tick();
         #1;
      end
      idle();

      // Starve limit 0: DMA wins outright while requesting
      z_cpu_req = 1; z_cpu_addr = 32'h10;
      z_dma_req = 1; z_dma_addr = 32'h20;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("z_dma_gnt", 32'(z_dma_gnt), 1);
         check("z_cpu_gnt", 32'(z_cpu_gnt), 0);
         tick();
         check("z_dma_rvalid", 32'(z_dma_rvalid), 1);
      end
      check("z_dma_rdata", z_dma_rdata, 32'hA5A5_0020);
      check("z_mem_we", 32'(z_mem_we), 0);
      check("z_mem_wdata", z_mem_wdata, 0);
      z_dma_req = 0;
      #1;
      check("z_cpu_gnt_after", 32'(z_cpu_gnt), 1);
      check("z_dma_gnt_after", 32'(z_dma_gnt), 0);
      tick();
      check("z_cpu_rvalid", 32'(z_cpu_rvalid), 1);
      check("z_cpu_rdata", z_cpu_rdata, 32'hA5A5_0010);
      z_cpu_req = 0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
